// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: byte width and FSM state encoding.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin winner selection: rotate the request vector so the search starts
// just above the last served requester, priority-encode, then un-rotate the index.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic            any,
  output logic [ID_W-1:0] winner
);

  logic [NREQ-1:0] rotated;
  logic [ID_W-1:0] src;
  logic            found;
  int              base;
  int              hit;

  // Rotate so bit 0 is the requester after 'last', then take the lowest set bit.
  always_comb begin
    rotated = '0;
    src     = '0;
    found   = 1'b0;
    hit     = 0;
    base    = (int'(last) + 1) % NREQ;
    for (int j = 0; j < NREQ; j++) begin
      src        = ID_W'((base + j) % NREQ);
      rotated[j] = req[src];
    end
    for (int j = 0; j < NREQ; j++) begin
      if (rotated[j] && !found) begin
        found = 1'b1;
        hit   = j;
      end
    end
    any    = found;
    winner = ID_W'((base + hit) % NREQ);
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one serial transmitter between NREQ byte producers in round-robin order.
// Issues one start pulse per granted byte and waits for the transmitter's busy
// handshake before serving the next requester. All outputs are registered.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int BUSY_TIMEOUT = 15,
  localparam int ID_W         = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        grant,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic [ID_W-1:0]        active_id,
  output logic                   active,
  output logic                   timeout_err
);

  localparam int CNT_W = 8;

  state_t           state;
  state_t           next_state;
  logic [ID_W-1:0]  last;
  logic [CNT_W-1:0] cnt;
  logic             pick_any;
  logic [ID_W-1:0]  pick_winner;
  logic             timeout_hit;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .last   (last),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // State register; reset parks the FSM in IDLE so a running frame must finish first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; busy rising in WAIT_HI takes priority over the timeout abort.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!tx_busy && pick_any) next_state = ST_START;
      end
      ST_START: next_state = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (tx_busy) begin
          next_state = ST_WAIT_LO;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          next_state  = ST_IDLE;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered outputs, captured byte/ID, round-robin pointer and busy-wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start    <= 1'b0;
      grant       <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
      tx_data     <= '0;
      active_id   <= '0;
      last        <= ID_W'(NREQ - 1);
      cnt         <= '0;
    end else begin
      tx_start    <= (next_state == ST_START);
      grant       <= (next_state == ST_START) ? (NREQ'(1) << pick_winner) : '0;
      active      <= (next_state != ST_IDLE);
      timeout_err <= timeout_hit;
      if (state == ST_IDLE && next_state == ST_START) begin
        tx_data   <= req_data[BYTE_W*int'(pick_winner) +: BYTE_W];
        active_id <= pick_winner;
      end
      if (state == ST_START) begin
        last <= active_id;
        cnt  <= '0;
      end else if (state == ST_WAIT_HI && !tx_busy) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single `async_transmitter` serial sender between `NREQ` independent byte producers. It sits between the producers and the transmitter's `start`/`data`/`busy` ports. It picks one pending requester, issues exactly one `tx_start` pulse with that requester's byte, then holds off until the transmitter has finished. It replaces hand-written per-message sequencing FSMs that drive the transmitter directly.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 15: cycles to wait for `tx_busy` to rise after `tx_start` before aborting; 1..255.
- `ID_W`, localparam: `$clog2(NREQ)`.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester "byte pending"; level, held until granted.
- `req_data`  in  8*NREQ  byte for requester i at bits [8i+7:8i]; stable while `req[i]`=1.
- `grant`  out  NREQ  one-hot, one-cycle pulse: byte of requester i consumed.
- `tx_start`  out  1  to transmitter start; one-cycle pulse.
- `tx_data`  out  8  to transmitter data; registered, stable from `tx_start` until return to IDLE.
- `tx_busy`  in  1  from transmitter busy.
- `active_id`  out  ID_W  index of the requester currently being served; valid when `active`=1.
- `active`  out  1  high from START through WAIT_LO.
- `timeout_err`  out  1  one-cycle pulse when the BUSY_TIMEOUT abort fires.

## Operation
- States: IDLE, START, WAIT_HI, WAIT_LO.
- IDLE:
  - If `tx_busy`=0 and `req`≠0: choose the winner `w` = first set bit searching upward (with wrap) from `last+1`.
  - At the same edge: latch `req_data[w]` into `tx_data`, set `active_id`=w, go to START.
  - If `tx_busy`=1, stay in IDLE regardless of `req`.
- START:
  - `tx_start`=1 and `grant[w]`=1 for exactly this cycle.
  - Set `last`=w, clear the timeout counter, go to WAIT_HI.
- WAIT_HI:
  - `tx_busy`=1 → WAIT_LO.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`: pulse `timeout_err`, go to IDLE.
  - The byte stays counted as granted; it is not retried.
- WAIT_LO:
  - `tx_busy`=0 → IDLE.
  - No timeout; the transmitter frame length is bounded by the transmitter itself.
- Requesters:
  - A requester dropping `req` before its grant is legal; it is simply not selected.
  - `req[i]` still high in the cycle after `grant[i]` counts as a new byte. It competes normally, at lowest priority behind the others.
- Reset:
  - `last`=NREQ-1, so requester 0 wins first after reset.
  - State=IDLE; `tx_data`=0, `active_id`=0, counter=0.
  - All outputs 0.
- Reset mid-transfer:
  - `tx_start` drops immediately.
  - A frame already running in the transmitter completes; IDLE then waits for `tx_busy`=0 before the next start.

## Timing
- Latency: `req` seen in IDLE at cycle 0 → `tx_start`/`grant` at cycle 1.
- All outputs are registered (Moore); no combinational path from `req` or `tx_busy` to any output.
- The transmitter raises busy one cycle after start, so WAIT_HI normally lasts 1 cycle.
- Minimum per-byte occupancy is 1 (START) + 1 (WAIT_HI) + frame length + 1 (IDLE).
- Back-to-back: after `tx_busy` falls, the next `tx_start` comes at the earliest 2 cycles later (WAIT_LO→IDLE, IDLE→START).
- Simultaneous requests are served strictly in round-robin order. With all requesters pending, each gets one byte per NREQ grants.
- `tx_data` does not change while `active`=1.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants `ST_IDLE`=2'd0, `ST_START`=2'd1, `ST_WAIT_HI`=2'd2, `ST_WAIT_LO`=2'd3;
  - the byte width constant (8).
- One sub-module: `rr_pick` (combinational, parameterised by NREQ).
  - Inputs: `req`, `last`. Outputs: `any`, `winner` index.
  - Implemented as a rotate, priority-encode, un-rotate.
- Top level holds the FSM, the timeout counter, the data/ID registers and the `last` pointer.

## Test plan
- Single request: after reset, `req`=4'b0001, byte 0x40.
  - Cycle 1: `tx_start`=1, `tx_data`=0x40, `grant`=4'b0001.
  - Model busy for 10 cycles; no second start until 2 cycles after busy falls.
- All pending: `req`=4'b1111 held high, bytes 0x40/0x30/0x2F/0x0A.
  - Grants in order 0,1,2,3,0.
  - Transmitter model sees bytes 0x40,0x30,0x2F,0x0A,0x40.
- Fairness after wrap: `last`=2, `req`=4'b0101 → requester 0 wins before 2. Then `req`=4'b0101 again → 2 wins.
- Busy timeout: `tx_busy` stuck 0 after start.
  - `timeout_err` pulses exactly BUSY_TIMEOUT cycles after WAIT_HI entry; FSM returns to IDLE.
  - The next request is served normally.
- Reset mid-frame: assert `rst` during WAIT_LO with `tx_busy`=1.
  - All outputs 0 immediately.
  - After release, no `tx_start` until `tx_busy`=0; the first grant goes to requester 0.
- External busy at idle: `tx_busy`=1 with `req`=4'b0010 → no `tx_start`. Busy drops at cycle k → `tx_start` at k+1.
